// File: rtl/io16_debounce_pkg.sv
// Shared constants for the 16-channel switch debouncer.
package io16_debounce_pkg;

   localparam int unsigned NUM_CH         = 16;
   localparam int unsigned DEF_TICK_DIV   = 50;
   localparam int unsigned DEF_STABLE_CNT = 16;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/io16_debounce_ch.sv
// One debounced switch channel: synchronizer, stability counter,
// accepted level, edge pulses and a clearable toggle bit.
module debounce_ch
   import io16_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
)
(
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   input  logic clr,
   output logic level,
   output logic rise,
   output logic fall,
   output logic toggle
);

   localparam int unsigned          CNT_W   = cnt_width(STABLE_CNT);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_CNT - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer for the asynchronous switch input.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

   // Stability count per tick; pulses are registered alongside the level
   // so they coincide with the first cycle of the new level.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (tick) begin
            if (sync_q2 == level) begin
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               level <= sync_q2;
               cnt   <= '0;
               rise  <= sync_q2;
               fall  <= ~sync_q2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Toggle flips on each accepted rise; a clear takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         toggle <= 1'b0;
      end else if (clr) begin
         toggle <= 1'b0;
      end else if (rise) begin
         toggle <= ~toggle;
      end
   end

endmodule

// File: rtl/io16_debounce.sv
// 16-channel switch debouncer: one shared sample-tick prescaler
// driving sixteen independent debounce_ch instances.
module io16_debounce
   import io16_debounce_pkg::*;
#(
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sw_in,
   input  logic [15:0] toggle_clr,
   output logic [15:0] sw_level,
   output logic [15:0] sw_rise,
   output logic [15:0] sw_fall,
   output logic [15:0] sw_toggle,
   output logic        tick
);

   localparam int unsigned      PRE_W   = cnt_width(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_cnt;

   // Free-running prescaler 0..TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_MAX) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_MAX);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_ch #(
         .STABLE_CNT (STABLE_CNT)
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .tick   (tick),
         .raw    (sw_in[g]),
         .clr    (toggle_clr[g]),
         .level  (sw_level[g]),
         .rise   (sw_rise[g]),
         .fall   (sw_fall[g]),
         .toggle (sw_toggle[g])
      );
   end

endmodule

// File: tb/tb_io16_debounce.sv
// Scoreboard bench for io16_debounce with TICK_DIV=4, STABLE_CNT=3.
module tb_io16_debounce;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] sw_in;
   logic [15:0] toggle_clr;
   logic [15:0] sw_level;
   logic [15:0] sw_rise;
   logic [15:0] sw_fall;
   logic [15:0] sw_toggle;
   logic        tick;

   typedef struct {
      int ch;
      bit is_rise;
   } ev_t;

   ev_t sb[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   io16_debounce #(
      .TICK_DIV   (4),
      .STABLE_CNT (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_in      (sw_in),
      .toggle_clr (toggle_clr),
      .sw_level   (sw_level),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_toggle  (sw_toggle),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Every edge pulse must match the next expected event in order.
   always @(negedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (sw_rise[i] === 1'b1 || sw_fall[i] === 1'b1) begin
            if (sb.size() == 0) begin
               check_val("unexpected_pulse_ch", i, -1);
            end else begin
               ev_t e;
               e = sb.pop_front();
               check_val("pulse_ch", i, e.ch);
               check_val("pulse_kind", int'({sw_rise[i], sw_fall[i]}), e.is_rise ? 2 : 1);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_level(input int ch, input logic val, input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (sw_level[ch] === val) seen = 1'b1;
      end
      check_val({tag, "_seen"}, int'(seen), 1);
      check_val({tag, "_latency_11_to_14"}, int'(n >= 11 && n <= 14), 1);
   endtask

   task automatic drive(input int ch, input logic val, input string tag);
      sw_in[ch] = val;
      sb.push_back('{ch, val});
      wait_level(ch, val, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  ph;
      int  n;
      bit  bounce_bad;

      reset      = 1'b1;
      sw_in      = '0;
      toggle_clr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_level",  int'(sw_level),  0);
      check_val("rst_rise",   int'(sw_rise),   0);
      check_val("rst_fall",   int'(sw_fall),   0);
      check_val("rst_toggle", int'(sw_toggle), 0);
      check_val("rst_tick",   int'(tick),      0);

      // Tick cadence after reset release.
      reset = 1'b0;
      ph    = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         ph = (ph + 1) % 4;
         @(negedge clk);
         check_val("tick", int'(tick), int'(ph == 3));
      end

      // Clean press and release on channel 8.
      drive(8, 1'b1, "press8");
      cycle();
      check_val("press8_toggle", int'(sw_toggle[8]), 1);
      repeat (5) cycle();
      drive(8, 1'b0, "rel8");
      cycle();
      check_val("rel8_toggle", int'(sw_toggle[8]), 1);

      // Bouncing input on channel 9 must never be accepted.
      bounce_bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sw_in[9] = ~sw_in[9];
         repeat (4) begin
            cycle();
            bounce_bad |= sw_level[9];
         end
      end
      sw_in[9] = 1'b0;
      repeat (30) begin
         cycle();
         bounce_bad |= sw_level[9];
      end
      check_val("bounce9_level_stayed_0", int'(bounce_bad), 0);

      // Clear coinciding with the rise wins on channel 10.
      sw_in[10] = 1'b1;
      sb.push_back('{10, 1'b1});
      n = 0;
      while (sw_rise[10] !== 1'b1 && n < 30) begin
         cycle();
         n++;
      end
      check_val("clr10_rise_seen", int'(sw_rise[10]), 1);
      toggle_clr[10] = 1'b1;
      cycle();
      toggle_clr[10] = 1'b0;
      check_val("clr10_toggle", int'(sw_toggle[10]), 0);
      check_val("clr10_level", int'(sw_level[10]), 1);
      drive(10, 1'b0, "rel10a");
      drive(10, 1'b1, "press10b");
      cycle();
      check_val("press10b_toggle", int'(sw_toggle[10]), 1);
      drive(10, 1'b0, "rel10b");
      drive(10, 1'b1, "press10c");
      cycle();
      check_val("press10c_toggle", int'(sw_toggle[10]), 0);
      drive(10, 1'b0, "rel10c");

      // Simultaneous acceptance on channels 1 and 2.
      sw_in[2:1] = 2'b11;
      sb.push_back('{1, 1'b1});
      sb.push_back('{2, 1'b1});
      wait_level(1, 1'b1, "sim1");
      check_val("sim2_level_same_cycle", int'(sw_level[2]), 1);
      cycle();

      // Reset in the middle of a count on channel 0.
      sw_in[2:1] = 2'b00;
      sw_in[0]   = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cycle();
      check_val("midrst_level",  int'(sw_level),  0);
      check_val("midrst_rise",   int'(sw_rise),   0);
      check_val("midrst_fall",   int'(sw_fall),   0);
      check_val("midrst_toggle", int'(sw_toggle), 0);
      check_val("midrst_tick",   int'(tick),      0);
      reset = 1'b0;
      sb.push_back('{0, 1'b1});
      wait_level(0, 1'b1, "rearm0");
      cycle();
      check_val("rearm0_toggle", int'(sw_toggle[0]), 1);

      repeat (20) cycle();
      check_val("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/io16_debounce.md
IO16_DEBOUNCE -- requirements
Module: io16_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50, meaning clk cycles per sample tick (50 MHz -> 1 MHz).
REQ-002 SHALL have parameter STABLE_CNT, default 16, meaning consecutive disagreeing ticks needed to accept a new level.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sw_in  input  16  raw asynchronous switch inputs s1..s16 (bit 0 = s1).
REQ-006 SHALL have port toggle_clr  input  16  per-channel synchronous clear of toggle state.
REQ-007 SHALL have port sw_level  output  16  debounced switch level, feeds the IO16 LED stage.
REQ-008 SHALL have port sw_rise  output  16  one-cycle pulse on accepted 0->1.
REQ-009 SHALL have port sw_fall  output  16  one-cycle pulse on accepted 1->0.
REQ-010 SHALL have port sw_toggle  output  16  per-channel state flipped on each accepted rise.
REQ-011 SHALL have port tick  output  1  sample-tick strobe, one clk wide.

Function
REQ-012 SHALL pass each sw_in bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL run one shared prescaler counting 0..TICK_DIV-1, wrapping to 0; tick is high only in the cycle the count equals TICK_DIV-1.
REQ-014 SHALL keep per-channel counter cnt, width clog2(STABLE_CNT), updated only when tick is high.
REQ-015 On tick, if synced input equals sw_level, SHALL clear cnt to 0 (any bounce restarts the count).
REQ-016 On tick, if synced input differs and cnt < STABLE_CNT-1, SHALL increment cnt.
REQ-017 On tick, if synced input differs and cnt == STABLE_CNT-1, SHALL load sw_level with the synced value and clear cnt.
REQ-018 SHALL assert sw_rise/sw_fall in exactly the clock cycle in which the new sw_level first appears, for one cycle only.
REQ-019 Latency from a stable sw_in change to sw_level SHALL be 2 clk + STABLE_CNT ticks, i.e. between 2+(STABLE_CNT-1)*TICK_DIV+1 and 2+STABLE_CNT*TICK_DIV clk cycles.
REQ-020 sw_toggle SHALL invert on a cycle with sw_rise, unless toggle_clr for that bit is high; toggle_clr SHALL win over a simultaneous rise (result 0).
REQ-021 Channels SHALL be fully independent; simultaneous acceptance on several channels SHALL produce simultaneous pulses.
REQ-022 cnt SHALL never exceed STABLE_CNT-1; no wrap-around.

Reset
REQ-023 While reset is high at a clk edge: prescaler, cnt, synchronizers, sw_level, sw_rise, sw_fall, sw_toggle, tick SHALL all become 0.
REQ-024 Reset mid-count SHALL discard partial counts; no pulse SHALL be emitted in or immediately after the reset cycle, even when sw_in is high (a held-high input is re-accepted as a rise after full latency).

Structure
REQ-025 A shared package SHALL hold the channel count (16) and default TICK_DIV/STABLE_CNT constants.
REQ-026 Per-channel logic (synchronizer, cnt, level, pulses, toggle) SHALL be a sub-module debounce_ch, instantiated 16 times; prescaler stays in the top.

Verification (TICK_DIV=4, STABLE_CNT=3)
REQ-027 Clean press: sw_in[8] 0->1 held -> sw_level[8]=1 within 11..14 clk, sw_rise[8] high exactly 1 cycle, sw_toggle[8]=1.
REQ-028 Bounce: sw_in[9] toggled every 4 clk for 40 clk, then held 0 -> sw_level[9], sw_rise[9], sw_fall[9] stay 0 throughout.
REQ-029 Release: after REQ-027, sw_in[8] 1->0 held -> sw_level[8]=0 within 11..14 clk, sw_fall[8] 1 cycle, sw_toggle[8] stays 1.
REQ-030 Clear priority: toggle_clr[10]=1 in the sw_rise[10] cycle -> sw_toggle[10]=0; two further presses with clr=0 -> 1, then 0.
REQ-031 Reset mid-count: sw_in[0]=1, reset pulsed 1 cycle at clk 6 -> all outputs 0; sw_level[0]=1 reached 11..14 clk after reset deasserts, one sw_rise[0].
REQ-032 Tick: tick high every 4th clk after reset, exactly 1 cycle wide.
